// File: rtl/biu_pkg.sv
// Bus interface unit shared definitions: fetch FSM states, reset defaults
// and the segment:offset to 20-bit physical address helper.
package biu_pkg;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_WAIT,
      FS_DROP
   } fetch_state_t;

   localparam int          DEF_QUEUE_BYTES = 6;
   localparam logic [15:0] DEF_RESET_CS    = 16'hFFFF;
   localparam logic [15:0] DEF_RESET_IP    = 16'h0000;

   // Sum is taken at 20 bits, so addresses past FFFFF wrap to low memory.
   function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
      return {seg, 4'b0000} + {4'b0000, off};
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer taking 0/1/2 bytes and giving up 1 byte per cycle.
// Head is combinational from registered state; caller guarantees no overflow, empty pops are ignored.
module byte_fifo
   import biu_pkg::*;
#(
   parameter int DEPTH = DEF_QUEUE_BYTES,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic [1:0]    push_cnt,
   input  logic [7:0]    push_b0,
   input  logic [7:0]    push_b1,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic [7:0]    head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] wr_ptr1;
   logic          pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign pop_ok  = pop && (count != '0);
   assign wr_ptr1 = ptr_inc(wr_ptr);
   assign head    = (count != '0) ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         case (push_cnt)
            2'd1: begin
               mem[wr_ptr] <= push_b0;
               wr_ptr      <= wr_ptr1;
            end
            2'd2: begin
               mem[wr_ptr]  <= push_b0;
               mem[wr_ptr1] <= push_b1;
               wr_ptr       <= ptr_inc(wr_ptr1);
            end
            default: ;
         endcase
         if (pop_ok) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CW'(push_cnt) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: word fetches from CS:IP into a byte FIFO, one byte per pop.
// Ack data lands in the queue the next cycle; fetching stalls until the registered count leaves room.
module prefetch_queue
   import biu_pkg::*;
#(
   parameter int          QUEUE_BYTES = DEF_QUEUE_BYTES,
   parameter logic [15:0] RESET_CS    = DEF_RESET_CS,
   parameter logic [15:0] RESET_IP    = DEF_RESET_IP
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [19:0] mem_addr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        byte_valid,
   output logic [7:0]  byte_out,
   input  logic        byte_pop,
   output logic [15:0] head_ip,
   input  logic        flush,
   input  logic [15:0] flush_cs,
   input  logic [15:0] flush_ip,
   output logic [2:0]  count
);

   fetch_state_t state;
   fetch_state_t state_nxt;
   logic [15:0]  cs;
   logic [15:0]  fetch_ip;
   logic [19:0]  addr_q;
   logic [19:0]  phys;
   logic [2:0]   free;
   logic         ack;
   logic         can_fetch;
   logic         issue;
   logic [1:0]   push_cnt;
   logic [7:0]   push_b0;
   logic [7:0]   push_b1;

   assign mem_req    = (state != FS_IDLE);
   assign mem_addr   = addr_q;
   assign ack        = mem_ack && mem_req;
   assign byte_valid = (count != 3'd0);
   assign head_ip    = fetch_ip - {13'd0, count};
   assign phys       = phys_addr(cs, fetch_ip);

   // Odd IP fetches the enclosing word and keeps only its upper byte.
   assign free      = 3'(QUEUE_BYTES) - count;
   assign can_fetch = fetch_ip[0] ? (free >= 3'd1) : (free >= 3'd2);

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      push_cnt  = 2'd0;
      push_b0   = fetch_ip[0] ? mem_rdata[15:8] : mem_rdata[7:0];
      push_b1   = mem_rdata[15:8];
      case (state)
         FS_IDLE: begin
            if (!flush && can_fetch) begin
               issue     = 1'b1;
               state_nxt = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (flush) begin
               state_nxt = ack ? FS_IDLE : FS_DROP;
            end else if (ack) begin
               push_cnt  = fetch_ip[0] ? 2'd1 : 2'd2;
               state_nxt = FS_IDLE;
            end
         end
         FS_DROP: begin
            if (ack) begin
               state_nxt = FS_IDLE;
            end
         end
         default: state_nxt = FS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FS_IDLE;
         cs       <= RESET_CS;
         fetch_ip <= RESET_IP;
         addr_q   <= '0;
      end else begin
         state <= state_nxt;
         if (flush) begin
            cs       <= flush_cs;
            fetch_ip <= flush_ip;
         end else if (push_cnt != 2'd0) begin
            fetch_ip <= fetch_ip + {14'd0, push_cnt};
         end
         if (issue) begin
            addr_q <= phys & 20'hFFFFE;
         end
      end
   end

   byte_fifo #(
      .DEPTH (QUEUE_BYTES),
      .CW    (3)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .push_cnt (push_cnt),
      .push_b0  (push_b0),
      .push_b1  (push_b1),
      .pop      (byte_pop && !flush),
      .count    (count),
      .head     (byte_out)
   );

endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: memory responder with programmable ack delay plus a byte/IP
// scoreboard filled on each ack and drained on pops, with directed timing checks.
module tb_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [19:0] mem_addr;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_ack = 1'b0;
   logic        byte_valid;
   logic [7:0]  byte_out;
   logic        byte_pop;
   logic [15:0] head_ip;
   logic        flush;
   logic [15:0] flush_cs;
   logic [15:0] flush_ip;
   logic [2:0]  count;

   always #5 clk = ~clk;

   prefetch_queue dut (
      .clk        (clk),
      .reset      (reset),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .byte_valid (byte_valid),
      .byte_out   (byte_out),
      .byte_pop   (byte_pop),
      .head_ip    (head_ip),
      .flush      (flush),
      .flush_cs   (flush_cs),
      .flush_ip   (flush_ip),
      .count      (count)
   );

   typedef struct packed {
      logic [7:0]  b;
      logic [15:0] ip;
   } sb_t;

   int          n_chk = 0;
   int          n_fail = 0;
   sb_t         sb[$];
   logic [19:0] addr_log[$];
   int          ack_delay = 0;
   bit          use_fixed = 1'b0;
   logic [15:0] fixed_word = 16'h0000;

   logic [15:0] m_cs = 16'hFFFF;
   logic [15:0] m_ip = 16'h0000;
   bit          m_drop = 1'b0;
   bit          in_req = 1'b0;
   logic [19:0] lock_addr = '0;
   int          wait_cnt = 0;
   logic [19:0] exp_addr;
   logic [15:0] w;
   bit          ack_now;
   sb_t         e;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [19:0] a);
      return a[7:0] ^ {a[19:16], a[11:8]} ^ 8'h5A;
   endfunction

   function automatic logic [31:0] log_at(input int i);
      if (i < addr_log.size()) return 32'(addr_log[i]);
      return 32'hFFFFFFFF;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int lim, input string tag);
      int k = 0;
      while (!mem_req && k < lim) begin
         cyc();
         k++;
      end
      check(tag, 32'(mem_req), 32'd1);
   endtask

   // Memory responder and reference model, evaluated with inputs settled before the next edge.
   always @(negedge clk) begin
      ack_now = 1'b0;
      if (reset) begin
         sb.delete();
         m_cs     = 16'hFFFF;
         m_ip     = 16'h0000;
         m_drop   = 1'b0;
         in_req   = 1'b0;
         wait_cnt = 0;
         mem_ack  = 1'b0;
      end else begin
         check("count", 32'(count), 32'(sb.size()));
         check("byte_valid", 32'(byte_valid), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            check("byte_out", 32'(byte_out), 32'(sb[0].b));
            check("head_ip", 32'(head_ip), 32'(sb[0].ip));
         end
         if (mem_req) begin
            if (!in_req) begin
               in_req    = 1'b1;
               lock_addr = mem_addr;
               wait_cnt  = 0;
               addr_log.push_back(mem_addr);
               if (!m_drop) begin
                  exp_addr    = {m_cs, 4'h0} + {4'h0, m_ip};
                  exp_addr[0] = 1'b0;
                  check("req_addr", 32'(mem_addr), 32'(exp_addr));
               end
            end else begin
               check("addr_hold", 32'(mem_addr), 32'(lock_addr));
            end
            if (wait_cnt >= ack_delay) ack_now = 1'b1;
            else wait_cnt++;
         end
         w = use_fixed ? fixed_word : {mem_byte(mem_addr + 20'd1), mem_byte(mem_addr)};
         mem_ack   = ack_now;
         mem_rdata = w;
         if (flush) begin
            sb.delete();
            m_cs   = flush_cs;
            m_ip   = flush_ip;
            m_drop = mem_req && !ack_now;
         end else begin
            if (byte_pop && sb.size() != 0) void'(sb.pop_front());
            if (ack_now) begin
               if (m_drop) begin
                  m_drop = 1'b0;
               end else if (m_ip[0]) begin
                  e.b = w[15:8]; e.ip = m_ip; sb.push_back(e);
                  m_ip = m_ip + 16'd1;
               end else begin
                  e.b = w[7:0];  e.ip = m_ip;         sb.push_back(e);
                  e.b = w[15:8]; e.ip = m_ip + 16'd1; sb.push_back(e);
                  m_ip = m_ip + 16'd2;
               end
            end
         end
         if (ack_now) in_req = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      reset = 1'b1; flush = 1'b0; byte_pop = 1'b0;
      flush_cs = 16'h0000; flush_ip = 16'h0000;
      repeat (3) cyc();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_byte_valid", 32'(byte_valid), 32'd0);
      check("rst_byte_out", 32'(byte_out), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_head_ip", 32'(head_ip), 32'h0000);
      reset = 1'b0;

      // Fill from reset with immediate acks.
      cyc();
      check("first_req", 32'(mem_req), 32'd1);
      check("first_addr", 32'(mem_addr), 32'hFFFF0);
      repeat (8) cyc();
      check("fill_count", 32'(count), 32'd6);
      check("fill_req", 32'(mem_req), 32'd0);
      check("fill_head_ip", 32'(head_ip), 32'h0000);
      check("fill_byte", 32'(byte_out), 32'(mem_byte(20'hFFFF0)));
      check("log_n", 32'(addr_log.size()), 32'd3);
      check("log0", log_at(0), 32'hFFFF0);
      check("log1", log_at(1), 32'hFFFF2);
      check("log2", log_at(2), 32'hFFFF4);
      byte_pop = 1'b1;
      repeat (6) cyc();
      byte_pop = 1'b0;
      repeat (20) cyc();

      // Flush to an odd IP: single upper byte fetched.
      use_fixed = 1'b1; fixed_word = 16'hAB12;
      flush_cs = 16'h1000; flush_ip = 16'h0003; flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("fl_valid", 32'(byte_valid), 32'd0);
      check("fl_req_low", 32'(mem_req), 32'd0);
      cyc();
      check("fl_req", 32'(mem_req), 32'd1);
      check("fl_addr", 32'(mem_addr), 32'h10002);
      cyc();
      check("odd_count", 32'(count), 32'd1);
      check("odd_byte", 32'(byte_out), 32'hAB);
      check("odd_head_ip", 32'(head_ip), 32'h0003);
      cyc();
      check("odd_next_addr", 32'(mem_addr), 32'h10004);
      use_fixed = 1'b0;

      // Count 5 with even IP holds off; pop credit only after registering.
      repeat (6) cyc();
      check("c5_count", 32'(count), 32'd5);
      check("c5_head_ip", 32'(head_ip), 32'h0003);
      repeat (3) cyc();
      check("c5_no_req", 32'(mem_req), 32'd0);
      ack_delay = 1;
      byte_pop = 1'b1;
      cyc();
      byte_pop = 1'b0;
      check("c4_count", 32'(count), 32'd4);
      check("c4_no_req_yet", 32'(mem_req), 32'd0);
      cyc();
      check("c4_req", 32'(mem_req), 32'd1);
      check("c4_addr", 32'(mem_addr), 32'h10008);
      cyc();
      byte_pop = 1'b1;
      cyc();
      byte_pop = 1'b0;
      check("pop_ack_count", 32'(count), 32'd5);
      check("pop_ack_head_ip", 32'(head_ip), 32'h0005);

      // Flush while a fetch is outstanding; its late ack must be dropped.
      ack_delay = 3;
      byte_pop = 1'b1;
      cyc();
      byte_pop = 1'b0;
      cyc();
      check("drop_req", 32'(mem_req), 32'd1);
      check("drop_addr0", 32'(mem_addr), 32'h1000A);
      flush_cs = 16'h2000; flush_ip = 16'h0010; flush = 1'b1;
      cyc();
      flush = 1'b0;
      for (int k = 0; k < 10 && mem_req; k++) begin
         check("drop_addr", 32'(mem_addr), 32'h1000A);
         check("drop_valid", 32'(byte_valid), 32'd0);
         cyc();
      end
      check("drop_done", 32'(mem_req), 32'd0);
      check("drop_valid_after", 32'(byte_valid), 32'd0);
      cyc();
      check("post_drop_req", 32'(mem_req), 32'd1);
      check("post_drop_addr", 32'(mem_addr), 32'h20010);
      check("post_drop_valid", 32'(byte_valid), 32'd0);

      // IP wrap; first flush lands on the cycle of an ack.
      ack_delay = 0;
      flush_cs = 16'h0000; flush_ip = 16'hFFFE; flush = 1'b1;
      cyc();
      flush = 1'b0;
      base = addr_log.size();
      repeat (12) cyc();
      check("wrap0_a", log_at(base), 32'h0FFFE);
      check("wrap0_b", log_at(base + 1), 32'h00000);
      check("wrap0_c", log_at(base + 2), 32'h00002);
      check("wrap0_head_ip", 32'(head_ip), 32'hFFFE);
      flush_cs = 16'hF000; flush_ip = 16'hFFFE; flush = 1'b1;
      cyc();
      flush = 1'b0;
      base = addr_log.size();
      repeat (12) cyc();
      check("wrapF_a", log_at(base), 32'hFFFFE);
      check("wrapF_b", log_at(base + 1), 32'hF0000);
      check("wrapF_count", 32'(count), 32'd6);

      // Reset in the middle of a fetch with 4 bytes queued.
      ack_delay = 5;
      byte_pop = 1'b1;
      repeat (2) cyc();
      byte_pop = 1'b0;
      wait_req(5, "mid_req");
      check("mid_count", 32'(count), 32'd4);
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("mid_rst_req", 32'(mem_req), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_valid", 32'(byte_valid), 32'd0);
      check("mid_rst_head_ip", 32'(head_ip), 32'h0000);
      ack_delay = 0;
      wait_req(5, "mid_rst_req2");
      check("mid_rst_addr", 32'(mem_addr), 32'hFFFF0);

      // Random pops, ack delays and occasional flushes.
      for (int i = 0; i < 400; i++) begin
         byte_pop  = 1'($urandom_range(0, 1));
         ack_delay = $urandom_range(0, 3);
         flush     = ($urandom_range(0, 24) == 0);
         flush_cs  = 16'($urandom);
         flush_ip  = 16'($urandom);
         cyc();
      end
      byte_pop = 1'b0;
      flush = 1'b0;
      repeat (20) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
